uart_dma_responder: RTL

UART_DMA_RESPONDER -- requirements
Module: uart_dma_responder

---
 rtl/uart_dma_pkg.sv | 15 +
 rtl/uart_dma_responder_if.sv | 36 +++
 rtl/byte_fifo.sv | 54 +++++
 rtl/uart_dma_responder.sv | 86 ++++++++
 4 files changed

// File: rtl/uart_dma_pkg.sv
// rtl/uart_dma_pkg.sv - shared depth, idle byte and drain FSM encodings for the UART DMA responder
package uart_dma_pkg;

    localparam int DEPTH = 64;
    localparam logic [7:0] IDLE_BYTE = 8'hFE;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/uart_dma_responder_if.sv
// rtl/uart_dma_responder_if.sv - DMA, transmitter and receiver signals of the UART DMA responder
interface uart_dma_responder_if #(parameter int DEPTH = uart_dma_pkg::DEPTH);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    i_uart_tx;
    logic          i_uart_tx_dv;
    logic          i_Tx_Send;
    logic          o_Tx_Done;
    logic [CW-1:0] o_Tx_Count;
    logic [7:0]    o_Tx_Byte;
    logic          o_Tx_DV;
    logic          i_Tx_Serial_Done;
    logic [7:0]    i_Rx_Byte;
    logic          i_Rx_DV;
    logic          i_Read_Flag;
    logic [7:0]    o_uart_rx;
    logic [CW-1:0] o_Rx_Count;
    logic [1:0]    o_Overflow;
    logic          i_Clear_Flags;

    modport master (
        output i_uart_tx, i_uart_tx_dv, i_Tx_Send, i_Tx_Serial_Done,
        output i_Rx_Byte, i_Rx_DV, i_Read_Flag, i_Clear_Flags,
        input  o_Tx_Done, o_Tx_Count, o_Tx_Byte, o_Tx_DV,
        input  o_uart_rx, o_Rx_Count, o_Overflow
    );

    modport slave (
        input  i_uart_tx, i_uart_tx_dv, i_Tx_Send, i_Tx_Serial_Done,
        input  i_Rx_Byte, i_Rx_DV, i_Read_Flag, i_Clear_Flags,
        output o_Tx_Done, o_Tx_Count, o_Tx_Byte, o_Tx_DV,
        output o_uart_rx, o_Rx_Count, o_Overflow
    );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with first-word-fall-through head
module byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/uart_dma_responder.sv
// rtl/uart_dma_responder.sv - DMA-facing TX/RX byte FIFOs with a drain FSM feeding a UART transmitter
module uart_dma_responder
    import uart_dma_pkg::*;
#(
    parameter int DEPTH = uart_dma_pkg::DEPTH
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    uart_dma_responder_if.slave  bus
);

    state_t     state;
    logic [7:0] tx_byte;
    logic [1:0] flags;
    logic [7:0] tx_head;
    logic [7:0] rx_head;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic       tx_pop;
    logic       tx_ovf;
    logic       rx_ovf;

    assign tx_pop = (state == ST_LOAD);

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (i_Clock),
        .rst_n (i_Reset_n),
        .push  (bus.i_uart_tx_dv),
        .wdata (bus.i_uart_tx),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (bus.o_Tx_Count)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (i_Clock),
        .rst_n (i_Reset_n),
        .push  (bus.i_Rx_DV),
        .wdata (bus.i_Rx_Byte),
        .pop   (bus.i_Read_Flag),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (bus.o_Rx_Count)
    );

    // A drop only happens when full and no pop frees a slot in the same cycle.
    assign tx_ovf = bus.i_uart_tx_dv && tx_full && !tx_pop;
    assign rx_ovf = bus.i_Rx_DV && rx_full && !bus.i_Read_Flag;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state   <= ST_IDLE;
            tx_byte <= IDLE_BYTE;
            flags   <= 2'b00;
        end else begin
            if (bus.i_Clear_Flags) begin
                flags <= 2'b00;
            end else begin
                flags <= flags | {rx_ovf, tx_ovf};
            end
            case (state)
                ST_IDLE:  if (bus.i_Tx_Send && !tx_empty) state <= ST_LOAD;
                ST_LOAD: begin
                    tx_byte <= tx_head;
                    state   <= ST_START;
                end
                ST_START: state <= ST_WAIT;
                ST_WAIT:  if (bus.i_Tx_Serial_Done) state <= ST_DONE;
                ST_DONE:  state <= (bus.i_Tx_Send && !tx_empty) ? ST_LOAD : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_Tx_DV    = (state == ST_START);
    assign bus.o_Tx_Done  = (state == ST_DONE);
    assign bus.o_Tx_Byte  = tx_byte;
    assign bus.o_uart_rx  = rx_empty ? IDLE_BYTE : rx_head;
    assign bus.o_Overflow = flags;

endmodule
